// File: rtl/s_fold_pkg.sv
// Shared widths and state encoding for the fold/unfold word pair.
package s_fold_pkg;

    localparam int unsigned HALF_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    // LOW expects the low half, FOLD expects lo ^ hi.
    typedef enum logic {
        LOW  = 1'b0,
        FOLD = 1'b1
    } state_e;

endpackage

// File: rtl/s_unfold_fifo2.sv
// Two-entry valid/ready buffer; the head entry drives the read side directly from flops.
module s_unfold_fifo2 #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full_c,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);

    logic         spare_valid_q;
    logic [W-1:0] spare_data_q;
    logic         pop_c;

    assign pop_c  = rd_valid && rd_ready;
    assign full_c = rd_valid && spare_valid_q;

    // Head/spare shuffle; writers never push while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            spare_valid_q <= 1'b0;
            spare_data_q  <= '0;
        end else if (pop_c) begin
            if (spare_valid_q) begin
                rd_data       <= spare_data_q;
                spare_valid_q <= wr_en;
                if (wr_en) begin
                    spare_data_q <= wr_data;
                end
            end else begin
                rd_valid <= wr_en;
                if (wr_en) begin
                    rd_data <= wr_data;
                end
            end
        end else if (wr_en) begin
            if (!rd_valid) begin
                rd_valid <= 1'b1;
                rd_data  <= wr_data;
            end else begin
                spare_valid_q <= 1'b1;
                spare_data_q  <= wr_data;
            end
        end
    end

endmodule

// File: rtl/s_unfold_64bit.sv
// Rebuilds {hi, lo} words from a lo beat followed by a folded (lo ^ hi) beat.
module s_unfold_64bit
    import s_fold_pkg::*;
#(
    parameter int unsigned HALF_W = HALF_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [HALF_W-1:0]   in_data,
    input  logic                in_flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] out_data,
    output logic [CNT_W-1:0]    word_cnt
);

    state_e                state_q, state_d;
    logic [HALF_W-1:0]     lo_q, lo_d;
    logic                  fifo_full_c;
    logic                  accept_c;
    logic                  push_c;
    logic [2*HALF_W-1:0]   push_data_c;

    // in_ready depends only on flops and in_flush, never on out_ready.
    assign in_ready    = !in_flush && ((state_q == LOW) || !fifo_full_c);
    assign accept_c    = in_valid && in_ready;
    assign push_data_c = {in_data ^ lo_q, lo_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
        end
    end

    // Flush wins over any concurrent beat (in_ready is already low then).
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        push_c  = 1'b0;
        if (in_flush) begin
            state_d = LOW;
            lo_d    = '0;
        end else if (accept_c) begin
            if (state_q == LOW) begin
                lo_d    = in_data;
                state_d = FOLD;
            end else begin
                push_c  = 1'b1;
                state_d = LOW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (push_c) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    s_unfold_fifo2 #(
        .W (2 * HALF_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push_c),
        .wr_data  (push_data_c),
        .full_c   (fifo_full_c),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (out_data)
    );

endmodule
